// File: rtl/instr_mem_pipe.sv
// Byte-addressed instruction/data memory with a 1-cycle registered read, an in-order response FIFO and error flags.
// Optional: define IMEM_PARITY_EN to store one even-parity bit per byte and add the rsp_perr output.
module instr_mem_pipe #(
  parameter int ADDR_W     = 12,
  parameter int DATA_BYTES = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [31:0]             req_addr,
  input  logic [DATA_BYTES-1:0]   req_be,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_wr,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
`ifdef IMEM_PARITY_EN
  output logic                    rsp_perr,
`endif
  output logic                    rsp_err
);
  localparam int DW      = 8 * DATA_BYTES;
  localparam int DEPTH_B = 2 ** ADDR_W;
  localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic          wr;
    logic          err;
    logic          perr;
    logic [DW-1:0] data;
  } rsp_t;

  logic [7:0]        r_mem [DEPTH_B];
  logic [DW-1:0]     r_rd_data;
  rsp_t              r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inf_valid, r_inf_wr, r_inf_err;
  logic              r_req_ready;

  logic              w_accept, w_pop, w_addr_err, w_perr;
  logic [ADDR_W-1:0] w_idx;
  logic [CNT_W-1:0]  w_count_nxt;
  rsp_t              w_push, w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Any misalignment or any address bit above ADDR_W makes the request an error.
  assign w_addr_err  = (|(req_addr & 32'(DATA_BYTES - 1))) | (|(req_addr >> ADDR_W));
  assign w_idx       = req_addr[ADDR_W-1:0];
  assign w_accept    = req_valid & r_req_ready;
  assign req_ready   = r_req_ready;
  assign rsp_valid   = (r_count != '0);
  assign w_pop       = rsp_valid & rsp_ready;
  assign w_count_nxt = r_count + CNT_W'(r_inf_valid) - CNT_W'(w_pop);

  // Byte i of a word lives at addr+i and maps to the i-th most significant lane.
  always_ff @(posedge clk) begin
    if (reset_n && w_accept && !w_addr_err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (req_wr && req_be[DATA_BYTES-1-i])
          r_mem[w_idx + ADDR_W'(i)] <= req_wdata[8*(DATA_BYTES-1-i) +: 8];
        if (!req_wr)
          r_rd_data[8*(DATA_BYTES-1-i) +: 8] <= r_mem[w_idx + ADDR_W'(i)];
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic                  r_par [DEPTH_B];
  logic [DATA_BYTES-1:0] r_rd_par;
  logic                  w_par_bad;

  always_ff @(posedge clk) begin
    if (reset_n && w_accept && !w_addr_err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (req_wr && req_be[DATA_BYTES-1-i])
          r_par[w_idx + ADDR_W'(i)] <= ^req_wdata[8*(DATA_BYTES-1-i) +: 8];
        if (!req_wr)
          r_rd_par[i] <= r_par[w_idx + ADDR_W'(i)];
      end
    end
  end

  always_comb begin
    w_par_bad = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++)
      if ((^r_rd_data[8*(DATA_BYTES-1-i) +: 8]) != r_rd_par[i]) w_par_bad = 1'b1;
  end

  assign w_perr = !r_inf_wr && !r_inf_err && w_par_bad;
`else
  assign w_perr = 1'b0;
`endif

  always_comb begin
    w_push      = '0;
    w_push.wr   = r_inf_wr;
    w_push.err  = r_inf_err | w_perr;
    w_push.perr = w_perr;
    w_push.data = (r_inf_wr | r_inf_err) ? '0 : r_rd_data;
  end

  // The in-flight stage always has a slot: acceptance already reserved it.
  always_ff @(posedge clk) begin
    if (reset_n && r_inf_valid) r_fifo[r_wptr] <= w_push;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inf_valid <= 1'b0;
      r_inf_wr    <= 1'b0;
      r_inf_err   <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
    end else begin
      r_inf_valid <= w_accept;
      if (w_accept) begin
        r_inf_wr  <= req_wr;
        r_inf_err <= w_addr_err;
      end
      if (r_inf_valid) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)       r_rptr <= ptr_inc(r_rptr);
      r_count     <= w_count_nxt;
      r_req_ready <= (int'(w_count_nxt) + int'(w_accept)) < RSP_DEPTH;
    end
  end

  assign w_head    = r_fifo[r_rptr];
  assign rsp_wr    = rsp_valid & w_head.wr;
  assign rsp_err   = rsp_valid & w_head.err;
  assign rsp_rdata = rsp_valid ? w_head.data : '0;
`ifdef IMEM_PARITY_EN
  assign rsp_perr  = rsp_valid & w_head.perr;
`endif
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: expected responses are queued at accept time
// from a byte-level memory model and compared at the head of the response stream.
module tb_instr_mem_pipe;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef IMEM_PARITY_EN
  logic        rsp_perr;
`endif

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mdl [logic [31:0]];
  int         n_checks = 0;
  int         n_pass = 0;

  instr_mem_pipe #(.ADDR_W(12), .DATA_BYTES(4), .RSP_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata),
`ifdef IMEM_PARITY_EN
    .rsp_perr(rsp_perr),
`endif
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // Scoreboard: the head response must match the oldest expectation every cycle it is valid.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      exp_t got;
      got.wr = rsp_wr; got.err = rsp_err; got.data = rsp_rdata;
      n_checks++;
      if (q.size() == 0)
        $display("FAIL unexpected_rsp got wr=%0b err=%0b data=%h, none expected", got.wr, got.err, got.data);
      else if (got !== q[0])
        $display("FAIL rsp_head got wr=%0b err=%0b data=%h, expected wr=%0b err=%0b data=%h",
                 got.wr, got.err, got.data, q[0].wr, q[0].err, q[0].data);
      else
        n_pass++;
      if (rsp_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  function automatic exp_t make_exp(input logic wr, input logic [31:0] addr,
                                    input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e.wr = wr;
    e.err = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
    e.data = '0;
    if (!e.err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr && be[3-i]) mdl[addr + 32'(i)] = wd[8*(3-i) +: 8];
        if (!wr) e.data[8*(3-i) +: 8] = mdl.exists(addr + 32'(i)) ? mdl[addr + 32'(i)] : 8'h00;
      end
    end
    return e;
  endfunction

  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    bit   acc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_be = be; req_wdata = wd;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (req_ready) begin
        e = make_exp(wr, addr, be, wd);
        q.push_back(e);
        acc = 1;
      end
    end
    n_checks++;
    if (!acc) $display("FAIL accept_timeout addr=%h req_ready stayed 0, expected 1", addr);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_wr !== 1'b0)
      $display("FAIL reset_outputs got rdy=%0b vld=%0b data=%h err=%0b wr=%0b, expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_wr);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    bit ok;
    rsp_ready = 1'b1;
    do_req(1'b1, 32'h010, 4'hF, 32'hDEADBEEF);
    wait_drain(ok);
    // Latency: read accepted at edge N must not be visible before N+1, and must be visible after it.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h010; req_be = 4'h0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rd_ready got %0b, expected 1", req_ready);
    else begin
      n_pass++;
      q.push_back(make_exp(1'b0, 32'h010, 4'h0, 32'h0));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL latency_early rsp_valid got %0b, expected 0", rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("FAIL latency_one got vld=%0b data=%h, expected 1 deadbeef", rsp_valid, rsp_rdata);
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_write_read queue=%0d, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_byte_enable();
    bit ok;
    rsp_ready = 1'b1;
    do_req(1'b1, 32'h010, 4'b0100, 32'h00AA0000);
    do_req(1'b0, 32'h010, 4'h0, 32'h0);
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_byte_enable queue=%0d, expected 0", q.size());
    else if (mdl[32'h011] !== 8'hAA) $display("FAIL model_byte got %h, expected aa", mdl[32'h011]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc = 0;
    rsp_ready = 1'b1;
    do_req(1'b1, 32'h014, 4'hF, 32'h11223344);
    do_req(1'b1, 32'h018, 4'hF, 32'h55667788);
    wait_drain(ok);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_be = 4'h0;
    for (int k = 0; k < 3; k++) begin
      req_addr = 32'h010 + 32'(4 * k);
      @(negedge clk);
      if (req_ready) begin
        q.push_back(make_exp(1'b0, req_addr, 4'h0, 32'h0));
        acc++;
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (req_ready) begin
        q.push_back(make_exp(1'b0, req_addr, 4'h0, 32'h0));
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_checks++;
    if (acc != 2) $display("FAIL bp_accepts got %0d, expected 2", acc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAABEEF)
      $display("FAIL bp_stall got rdy=%0b vld=%0b data=%h, expected 0 1 deaabeef", req_ready, rsp_valid, rsp_rdata);
    else n_pass++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_backpressure queue=%0d, expected 0", q.size());
    else n_pass++;
    do_req(1'b0, 32'h018, 4'h0, 32'h0);
    wait_drain(ok);
  endtask

  task automatic test_errors();
    bit ok;
    rsp_ready = 1'b1;
    do_req(1'b1, 32'h000, 4'hF, 32'h01020304);
    do_req(1'b0, 32'h013, 4'h0, 32'h0);
    do_req(1'b0, 32'h1000, 4'h0, 32'h0);
    do_req(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    do_req(1'b1, 32'h012, 4'hF, 32'hFFFFFFFF);
    do_req(1'b0, 32'h000, 4'h0, 32'h0);
    do_req(1'b0, 32'h010, 4'h0, 32'h0);
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_errors queue=%0d, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    bit acc;
    @(posedge clk); #1;
    for (int k = 0; k < 24; k++) begin
      req_valid = 1'b1;
      req_wr    = (k < 8) ? 1'b1 : 1'b0;
      req_addr  = 32'h020 + 32'(4 * (k % 8)) + ((k == 13) ? 32'h1 : 32'h0);
      req_be    = 4'($urandom_range(1, 15));
      req_wdata = $urandom;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (req_ready) begin
          e = make_exp(req_wr, req_addr, req_be, req_wdata);
          q.push_back(e);
          acc = 1;
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (!acc) $display("FAIL b2b_accept k=%0d not accepted, expected accept", k);
      else n_pass++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_b2b queue=%0d, expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h010, 4'h0, 32'h0);
    do_req(1'b0, 32'h014, 4'h0, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h010; req_be = 4'hF; req_wdata = 32'h0BADF00D;
    q.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_mid got vld=%0b rdy=%0b, expected 0 1", rsp_valid, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    do_req(1'b0, 32'h010, 4'h0, 32'h0);
    n_checks++;
    if (q.size() == 0 || q[q.size()-1].data !== 32'hDEAABEEF)
      $display("FAIL model_after_reset expected entry missing or not deaabeef");
    else n_pass++;
    wait_drain(ok);
    n_checks++;
    if (!ok) $display("FAIL drain_reset_mid queue=%0d, expected 0", q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
